// File: rtl/timekeep_alarm_unit.sv
// timekeep_alarm_unit: hh:mm:ss time of day with keypad set mode and N_ALARM
// snoozable alarm channels, compared on each second tick.
module timekeep_alarm_unit #(
    parameter int N_ALARM    = 2,
    parameter int ASEL_W     = 1,
    parameter int SNOOZE_MIN = 5,
    parameter int H24        = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sec_tick,
    input  logic               set_mode,
    input  logic [1:0]         set_field,
    input  logic [5:0]         set_val,
    input  logic               set_load,
    input  logic               alm_wr,
    input  logic [ASEL_W-1:0]  alm_sel,
    input  logic [4:0]         alm_hr,
    input  logic [5:0]         alm_min,
    input  logic               alm_en_in,
    input  logic               alm_ack,
    input  logic               alm_snooze,
    output logic [4:0]         hh_disp,
    output logic [5:0]         mm,
    output logic [5:0]         ss,
    output logic               pm,
    output logic               in_set,
    output logic               set_err,
    output logic [N_ALARM-1:0] alarm_hit,
    output logic               alarm_any
);
    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] SET = 1'b1;

    logic [0:0] state_q, state_d;
    logic [4:0] hh_q, hh_d;
    logic [5:0] mm_q, mm_d, ss_q, ss_d;
    logic [N_ALARM-1:0][4:0] ahr_q, ahr_d, shr_q, shr_d;
    logic [N_ALARM-1:0][5:0] amin_q, amin_d, smin_q, smin_d;
    logic [N_ALARM-1:0] en_q, en_d, pend_q, pend_d, hit_q, hit_d;
    logic err_q, err_d;
    logic [4:0] t_hh, z_hh;
    logic [5:0] t_mm, t_ss, z_mm;
    logic [6:0] z_sum;
    logic tick_run, load_ok, wr_ok, wr_i, snz_i;

    always_comb begin
        tick_run = state_q == RUN && sec_tick;
        t_ss = ss_q == 6'd59 ? 6'd0 : ss_q + 6'd1;
        t_mm = ss_q != 6'd59 ? mm_q : mm_q == 6'd59 ? 6'd0 : mm_q + 6'd1;
        t_hh = (ss_q != 6'd59 || mm_q != 6'd59) ? hh_q : hh_q == 5'd23 ? 5'd0 : hh_q + 5'd1;
        // snooze target: current hh:mm plus SNOOZE_MIN, wrapping into hours
        z_sum = 7'(mm_q) + 7'(SNOOZE_MIN);
        z_mm = z_sum >= 7'd60 ? 6'(z_sum - 7'd60) : z_sum[5:0];
        z_hh = z_sum < 7'd60 ? hh_q : hh_q == 5'd23 ? 5'd0 : hh_q + 5'd1;
        load_ok = set_field <= 2'd1 ? set_val <= 6'd59 : set_field == 2'd2 ? set_val <= 6'd23 : 1'b0;
        wr_ok = 32'(alm_sel) < N_ALARM && alm_hr <= 5'd23 && alm_min <= 6'd59;
        err_d = (state_q == SET && set_load && !load_ok) || (alm_wr && !wr_ok);
        state_d = set_mode ? SET : RUN;
        hh_d = tick_run ? t_hh : hh_q;
        mm_d = tick_run ? t_mm : mm_q;
        ss_d = tick_run ? t_ss : ss_q;
        if (state_q == SET && set_load && load_ok) begin
            hh_d = set_field == 2'd2 ? set_val[4:0] : hh_q;
            mm_d = set_field == 2'd1 ? set_val : mm_q;
            ss_d = set_field == 2'd0 ? set_val : ss_q;
        end
        ahr_d = ahr_q;
        amin_d = amin_q;
        en_d = en_q;
        shr_d = shr_q;
        smin_d = smin_q;
        pend_d = pend_q;
        hit_d = hit_q;
        wr_i = 1'b0;
        snz_i = 1'b0;
        for (int i = 0; i < N_ALARM; i++) begin
            wr_i = alm_wr && wr_ok && alm_sel == ASEL_W'(i);
            snz_i = alm_snooze && !alm_ack && hit_q[i];
            // a fresh match outranks ack/snooze clearing in the same cycle
            hit_d[i] = (tick_run && en_q[i] && t_ss == 6'd0
                        && t_hh == (pend_q[i] ? shr_q[i] : ahr_q[i])
                        && t_mm == (pend_q[i] ? smin_q[i] : amin_q[i]))
                       || (hit_q[i] && !alm_ack && !alm_snooze);
            pend_d[i] = !alm_ack && !wr_i && (pend_q[i] || snz_i);
            shr_d[i] = snz_i ? z_hh : shr_q[i];
            smin_d[i] = snz_i ? z_mm : smin_q[i];
            ahr_d[i] = wr_i ? alm_hr : ahr_q[i];
            amin_d[i] = wr_i ? alm_min : amin_q[i];
            en_d[i] = wr_i ? alm_en_in : en_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            hh_q <= '0;
            mm_q <= '0;
            ss_q <= '0;
            ahr_q <= '0;
            amin_q <= '0;
            en_q <= '0;
            shr_q <= '0;
            smin_q <= '0;
            pend_q <= '0;
            hit_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hh_q <= hh_d;
            mm_q <= mm_d;
            ss_q <= ss_d;
            ahr_q <= ahr_d;
            amin_q <= amin_d;
            en_q <= en_d;
            shr_q <= shr_d;
            smin_q <= smin_d;
            pend_q <= pend_d;
            hit_q <= hit_d;
            err_q <= err_d;
        end
    end

    assign hh_disp = H24 != 0 ? hh_q : hh_q == 5'd0 ? 5'd12 : hh_q > 5'd12 ? hh_q - 5'd12 : hh_q;
    assign pm = H24 == 0 && hh_q >= 5'd12;
    assign mm = mm_q;
    assign ss = ss_q;
    assign in_set = state_q == SET;
    assign set_err = err_q;
    assign alarm_hit = hit_q;
    assign alarm_any = |hit_q;
endmodule

// File: tb/tb_timekeep_alarm_unit.sv
// tb_timekeep_alarm_unit: directed plus randomized checks of the 12-hour, two-channel
// configuration against a seconds-of-day reference model.
module tb_timekeep_alarm_unit;
    localparam int N = 2;
    localparam int SNZ = 5;

    logic clk = 1'b0, rst_n = 1'b0;
    logic sec_tick = 0, set_mode = 0, set_load = 0, alm_wr = 0, alm_en_in = 0, alm_ack = 0, alm_snooze = 0;
    logic [1:0] set_field = 0, alm_sel = 0;
    logic [5:0] set_val = 0, alm_min = 0;
    logic [4:0] alm_hr = 0;
    logic [4:0] hh_disp;
    logic [5:0] mm, ss;
    logic pm, in_set, set_err, alarm_any;
    logic [N-1:0] alarm_hit;

    int total = 0, bad = 0;
    int tod, snz[N], ahr[N], amin[N];
    bit mset, merr;
    bit [N-1:0] en, pend, hit;

    timekeep_alarm_unit #(.N_ALARM(N), .ASEL_W(2), .SNOOZE_MIN(SNZ), .H24(0)) dut (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .set_mode(set_mode), .set_field(set_field),
        .set_val(set_val), .set_load(set_load), .alm_wr(alm_wr), .alm_sel(alm_sel), .alm_hr(alm_hr),
        .alm_min(alm_min), .alm_en_in(alm_en_in), .alm_ack(alm_ack), .alm_snooze(alm_snooze),
        .hh_disp(hh_disp), .mm(mm), .ss(ss), .pm(pm), .in_set(in_set), .set_err(set_err),
        .alarm_hit(alarm_hit), .alarm_any(alarm_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        tod = 0; mset = 0; merr = 0; en = '0; pend = '0; hit = '0;
        for (int i = 0; i < N; i++) begin
            snz[i] = 0; ahr[i] = 0; amin[i] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        int h;
        h = tod / 3600;
        chk({tag, ":hh_disp"}, 32'(hh_disp), h == 0 ? 12 : h > 12 ? h - 12 : h);
        chk({tag, ":pm"}, 32'(pm), 32'(h >= 12));
        chk({tag, ":mm"}, 32'(mm), (tod / 60) % 60);
        chk({tag, ":ss"}, 32'(ss), tod % 60);
        chk({tag, ":in_set"}, 32'(in_set), 32'(mset));
        chk({tag, ":set_err"}, 32'(set_err), 32'(merr));
        chk({tag, ":alarm_hit"}, 32'(alarm_hit), 32'(hit));
        chk({tag, ":alarm_any"}, 32'(alarm_any), 32'(hit != 0));
    endtask

    task automatic step(input string tag = "step");
        int ntod, h, m, s, tgt;
        bit lok, wok, mt, snzi, wri;
        bit [N-1:0] nhit, npend;
        lok = (set_field <= 1 && set_val <= 59) || (set_field == 2 && set_val <= 23);
        wok = alm_sel < N && alm_hr <= 23 && alm_min <= 59;
        ntod = tod;
        if (!mset && sec_tick) ntod = (tod + 1) % 86400;
        if (mset && set_load && lok) begin
            h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
            if (set_field == 0) s = int'(set_val);
            if (set_field == 1) m = int'(set_val);
            if (set_field == 2) h = int'(set_val);
            ntod = h * 3600 + m * 60 + s;
        end
        for (int i = 0; i < N; i++) begin
            tgt = pend[i] ? snz[i] : ahr[i] * 60 + amin[i];
            mt = !mset && sec_tick && en[i] && ntod % 60 == 0 && ntod / 60 == tgt;
            nhit[i] = mt || (hit[i] && !alm_ack && !alm_snooze);
            snzi = alm_snooze && !alm_ack && hit[i];
            wri = alm_wr && wok && alm_sel == i;
            npend[i] = !alm_ack && !wri && (pend[i] || snzi);
            if (snzi) snz[i] = (tod / 60 + SNZ) % 1440;
            if (wri) begin
                ahr[i] = int'(alm_hr); amin[i] = int'(alm_min); en[i] = alm_en_in;
            end
        end
        merr = (mset && set_load && !lok) || (alm_wr && !wok);
        mset = set_mode;
        tod = ntod; hit = nhit; pend = npend;
        @(posedge clk);
        #1;
        sec_tick = 0; set_load = 0; alm_wr = 0; alm_ack = 0; alm_snooze = 0;
        check_all(tag);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            sec_tick = 1;
            step();
        end
    endtask

    task automatic load(input int f, input int v);
        set_field = 2'(f); set_val = 6'(v); set_load = 1;
        step();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        set_mode = 1; step();
        load(2, h); load(1, m); load(0, s);
        set_mode = 0; step();
    endtask

    task automatic wr(input int sel, input int h, input int m, input bit e);
        alm_sel = 2'(sel); alm_hr = 5'(h); alm_min = 6'(m); alm_en_in = e; alm_wr = 1;
        step();
    endtask

    initial begin
        mreset();
        #12;
        check_all("reset");
        @(negedge clk) rst_n = 1;
        // asynchronous reset mid-count at 13:45:12
        set_time(13, 45, 9);
        tick(3);
        chk("pre_rst_hh", 32'(hh_disp), 1);
        chk("pre_rst_pm", 32'(pm), 1);
        #2 rst_n = 0;
        #1;
        mreset();
        chk("async_hh", 32'(hh_disp), 12);
        chk("async_mm", 32'(mm), 0);
        chk("async_ss", 32'(ss), 0);
        chk("async_pm", 32'(pm), 0);
        chk("async_any", 32'(alarm_any), 0);
        @(negedge clk) rst_n = 1;
        // SET mode: bad hour rejected, time frozen during ticks
        set_mode = 1; step();
        load(2, 24);
        chk("err_pulse", 32'(set_err), 1);
        step();
        chk("err_one_cycle", 32'(set_err), 0);
        chk("hh_unchanged", 32'(hh_disp), 12);
        load(2, 7); load(1, 30); load(0, 0);
        tick(3);
        chk("frozen_hh", 32'(hh_disp), 7);
        chk("frozen_mm", 32'(mm), 30);
        chk("frozen_ss", 32'(ss), 0);
        load(3, 1);
        chk("field3_err", 32'(set_err), 1);
        set_mode = 0; step();
        tick(1);
        chk("resume_ss", 32'(ss), 1);
        load(2, 5);
        chk("run_load_ignored", 32'(hh_disp), 7);
        // ch1 alarm and snooze
        set_time(7, 30, 59);
        wr(1, 7, 31, 1);
        tick(1);
        chk("ch1_hit", 32'(alarm_hit), 2);
        chk("ch1_any", 32'(alarm_any), 1);
        alm_snooze = 1; step();
        chk("snooze_clear", 32'(alarm_hit), 0);
        tick(299);
        chk("snooze_wait", 32'(alarm_hit), 0);
        tick(1);
        chk("snooze_fire", 32'(alarm_hit), 2);
        chk("snooze_mm", 32'(mm), 36);
        alm_ack = 1; step();
        wr(1, 0, 0, 0);
        // ch0 snooze across midnight
        wr(0, 23, 58, 1);
        set_time(23, 57, 59);
        tick(1);
        chk("ch0_hit", 32'(alarm_hit), 1);
        alm_snooze = 1; step();
        tick(119);
        chk("pm_2359", 32'(pm), 1);
        chk("hh_2359", 32'(hh_disp), 11);
        tick(1);
        chk("wrap_hh", 32'(hh_disp), 12);
        chk("wrap_pm", 32'(pm), 0);
        chk("wrap_ss", 32'(ss), 0);
        tick(180);
        chk("midnight_snooze", 32'(alarm_hit), 1);
        alm_ack = 1; alm_snooze = 1; step();
        chk("ack_wins", 32'(alarm_hit), 0);
        tick(300);
        chk("pend_cleared", 32'(alarm_hit), 0);
        // rejected channel index, then write racing a match of the old value
        wr(2, 1, 1, 1);
        chk("sel_err", 32'(set_err), 1);
        wr(0, 24, 0, 1);
        chk("hr_err", 32'(set_err), 1);
        wr(0, 0, 9, 1);
        tick(59);
        sec_tick = 1; alm_sel = 0; alm_hr = 10; alm_min = 0; alm_en_in = 1; alm_wr = 1;
        step();
        chk("old_value_match", 32'(alarm_hit), 1);
        alm_ack = 1; sec_tick = 1; set_time(10, 0, 0);
        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            sec_tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 149) == 0) set_mode = ~set_mode;
            if ($urandom_range(0, 9) == 0) begin
                set_load = 1; set_field = 2'($urandom_range(0, 3)); set_val = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 39) == 0) begin
                alm_wr = 1; alm_sel = 2'($urandom_range(0, 2)); alm_en_in = 1'($urandom_range(0, 3) != 0);
                alm_hr = $urandom_range(0, 5) == 0 ? 5'($urandom_range(0, 31)) : 5'(tod / 3600);
                alm_min = $urandom_range(0, 5) == 0 ? 6'($urandom_range(0, 63)) : 6'(((tod / 60) + $urandom_range(0, 2)) % 60);
            end
            alm_ack = $urandom_range(0, 99) == 0;
            alm_snooze = $urandom_range(0, 29) == 0;
            step("rand");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
